tmr_count_ctrl: RTL and testbench

Counter sequencer for one 8-bit timer channel. Consumes the count-enable pulse from the channel clock-select logic and sequences the TCNT counter. Handles compare match A/B against TCORA/TCORB, counter-clear source selection, overflow, and the status flags and interrupt requests. Sits between the APB register file and the clock-select channel. Its compare-A and overflow pulses feed the cascaded-signal input of the neighbouring channel.

---
 rtl/tmr_pkg.sv | 29 ++
 rtl/tmr_flag_bit.sv | 22 ++
 rtl/tmr_count_ctrl.sv | 145 ++++++++++++++
 tb/tb_tmr_count_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared types and constants for the 8-bit timer counter sequencer.
package tmr_pkg;

    localparam int CNT_W_DFLT = 8;

    localparam int FLG_OVF = 0;
    localparam int FLG_CMA = 1;
    localparam int FLG_CMB = 2;

    typedef enum logic [1:0] {
        CCLR_NONE = 2'b00,
        CCLR_CMA  = 2'b01,
        CCLR_CMB  = 2'b10,
        CCLR_EXT  = 2'b11
    } cclr_e;

    typedef enum logic [1:0] {
        OS_NC  = 2'b00,
        OS_LO  = 2'b01,
        OS_HI  = 2'b10,
        OS_TGL = 2'b11
    } os_e;

    typedef enum logic {
        ST_COUNT   = 1'b0,
        ST_WR_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/tmr_flag_bit.sv
// Sticky status flag: write-1-to-clear with set priority, plus a one-cycle
// registered pulse for every set event.
module tmr_flag_bit (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_set,
    input  logic i_clr,
    output logic o_flag,
    output logic o_pulse
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_flag  <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            o_flag  <= i_set | (o_flag & ~i_clr);
            o_pulse <= i_set;
        end
    end

endmodule

// File: rtl/tmr_count_ctrl.sv
// TCNT sequencer for one timer channel: compare A/B, clear select, overflow,
// flags and interrupts. Optional TMO pin driver behind TMR_TMO_OUT_EN.
module tmr_count_ctrl
    import tmr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DFLT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tcnt_en,
    input  logic [1:0]       i_cclr,
    input  logic             i_ext_rst_edge,
    input  logic [CNT_W-1:0] i_tcora,
    input  logic [CNT_W-1:0] i_tcorb,
    input  logic             i_tcnt_wr,
    input  logic [CNT_W-1:0] i_tcnt_wdata,
    input  logic [2:0]       i_flag_clr,
    input  logic [2:0]       i_ie,
`ifdef TMR_TMO_OUT_EN
    input  logic [3:0]       i_os,
`endif
    output logic [CNT_W-1:0] o_tcnt,
    output logic             o_cmfa,
    output logic             o_cmfb,
    output logic             o_ovf,
    output logic             o_cmia,
    output logic             o_cmib,
    output logic             o_ovi,
    output logic             o_cmpa_pulse,
    output logic             o_ovf_pulse,
    output logic             o_tmo
);

    state_e           state, state_nxt;
    cclr_e            cclr;
    logic [CNT_W-1:0] tcnt;
    logic             ev_a, ev_b, ev_ovf, clr_cnt;
    logic [2:0]       flg_set, flg, pls;
    logic             unused_cmb_pls;

    assign cclr = cclr_e'(i_cclr);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_COUNT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_COUNT;
        if (i_tcnt_wr) state_nxt = ST_WR_HOLD;

        // Compares are blocked both during a CPU write and in the cycle after it
        ev_a = i_tcnt_en & (tcnt == i_tcora) & (state == ST_COUNT) & ~i_tcnt_wr;
        ev_b = i_tcnt_en & (tcnt == i_tcorb) & (state == ST_COUNT) & ~i_tcnt_wr;

        clr_cnt = 1'b0;
        case (cclr)
            CCLR_CMA:  clr_cnt = ev_a;
            CCLR_CMB:  clr_cnt = ev_b;
            CCLR_EXT:  clr_cnt = i_ext_rst_edge;
            CCLR_NONE: clr_cnt = 1'b0;
            default:   clr_cnt = 1'b0;
        endcase

        ev_ovf = i_tcnt_en & (tcnt == {CNT_W{1'b1}}) & ~i_tcnt_wr & ~clr_cnt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)          tcnt <= '0;
        else if (i_tcnt_wr) tcnt <= i_tcnt_wdata;
        else if (clr_cnt)   tcnt <= '0;
        else if (i_tcnt_en) tcnt <= tcnt + 1'b1;
    end

    always_comb begin
        flg_set          = '0;
        flg_set[FLG_OVF] = ev_ovf;
        flg_set[FLG_CMA] = ev_a;
        flg_set[FLG_CMB] = ev_b;
    end

    for (genvar g = 0; g < 3; g++) begin : g_flag
        tmr_flag_bit u_flag (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_set   (flg_set[g]),
            .i_clr   (i_flag_clr[g]),
            .o_flag  (flg[g]),
            .o_pulse (pls[g])
        );
    end

    assign o_tcnt         = tcnt;
    assign o_ovf          = flg[FLG_OVF];
    assign o_cmfa         = flg[FLG_CMA];
    assign o_cmfb         = flg[FLG_CMB];
    assign o_ovi          = flg[FLG_OVF] & i_ie[FLG_OVF];
    assign o_cmia         = flg[FLG_CMA] & i_ie[FLG_CMA];
    assign o_cmib         = flg[FLG_CMB] & i_ie[FLG_CMB];
    assign o_ovf_pulse    = pls[FLG_OVF];
    assign o_cmpa_pulse   = pls[FLG_CMA];
    assign unused_cmb_pls = pls[FLG_CMB];

`ifdef TMR_TMO_OUT_EN
    os_e  osa, osb;
    logic tmo, tmo_a, tmo_nxt;

    assign osa = os_e'(i_os[1:0]);
    assign osb = os_e'(i_os[3:2]);

    // A's action first, then B's on top: B's set/clear wins, toggles XOR
    always_comb begin
        tmo_a = tmo;
        if (ev_a) begin
            case (osa)
                OS_LO:  tmo_a = 1'b0;
                OS_HI:  tmo_a = 1'b1;
                OS_TGL: tmo_a = ~tmo;
                OS_NC:  tmo_a = tmo;
                default: tmo_a = tmo;
            endcase
        end
        tmo_nxt = tmo_a;
        if (ev_b) begin
            case (osb)
                OS_LO:  tmo_nxt = 1'b0;
                OS_HI:  tmo_nxt = 1'b1;
                OS_TGL: tmo_nxt = ~tmo_a;
                OS_NC:  tmo_nxt = tmo_a;
                default: tmo_nxt = tmo_a;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) tmo <= 1'b0;
        else       tmo <= tmo_nxt;
    end

    assign o_tmo = tmo;
`else
    assign o_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_tmr_count_ctrl.sv
// Directed plus random stimulus for tmr_count_ctrl, checked against a
// cycle-level reference model built from the counter/flag rules.
module tb_tmr_count_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, wr, ext;
    logic [1:0] cclr;
    logic [7:0] tcora, tcorb, wdata;
    logic [2:0] fclr, ie;
    logic [3:0] os;

    logic [7:0] o_tcnt;
    logic o_cmfa, o_cmfb, o_ovf, o_cmia, o_cmib, o_ovi;
    logic o_cmpa_pulse, o_ovf_pulse, o_tmo;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_cnt;
    bit m_hold;
    bit m_ovf, m_cma, m_cmb;
    bit m_pa, m_po;
    bit m_tmo;

    always #5 clk = ~clk;

    tmr_count_ctrl #(.CNT_W(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_tcnt_en      (en),
        .i_cclr         (cclr),
        .i_ext_rst_edge (ext),
        .i_tcora        (tcora),
        .i_tcorb        (tcorb),
        .i_tcnt_wr      (wr),
        .i_tcnt_wdata   (wdata),
        .i_flag_clr     (fclr),
        .i_ie           (ie),
`ifdef TMR_TMO_OUT_EN
        .i_os           (os),
`endif
        .o_tcnt         (o_tcnt),
        .o_cmfa         (o_cmfa),
        .o_cmfb         (o_cmfb),
        .o_ovf          (o_ovf),
        .o_cmia         (o_cmia),
        .o_cmib         (o_cmib),
        .o_ovi          (o_ovi),
        .o_cmpa_pulse   (o_cmpa_pulse),
        .o_ovf_pulse    (o_ovf_pulse),
        .o_tmo          (o_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit os_apply(input bit t, input logic [1:0] code);
        if (code == 2'd1) return 1'b0;
        if (code == 2'd2) return 1'b1;
        if (code == 2'd3) return ~t;
        return t;
    endfunction

    // advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit ea, eb, clr, ov;
        ea  = en && (m_cnt == int'(tcora)) && !m_hold && !wr;
        eb  = en && (m_cnt == int'(tcorb)) && !m_hold && !wr;
        clr = (cclr == 2'd1 && ea) || (cclr == 2'd2 && eb) || (cclr == 2'd3 && ext);
        ov  = en && (m_cnt == 255) && !wr && !clr;
        if (rst) begin
            m_cnt = 0; m_hold = 0; m_ovf = 0; m_cma = 0; m_cmb = 0;
            m_pa = 0; m_po = 0; m_tmo = 0;
        end else begin
`ifdef TMR_TMO_OUT_EN
            if (ea) m_tmo = os_apply(m_tmo, os[1:0]);
            if (eb) m_tmo = os_apply(m_tmo, os[3:2]);
`endif
            if (wr)       m_cnt = int'(wdata);
            else if (clr) m_cnt = 0;
            else if (en)  m_cnt = (m_cnt + 1) % 256;
            m_hold = wr;
            m_ovf  = ov || (m_ovf && !fclr[0]);
            m_cma  = ea || (m_cma && !fclr[1]);
            m_cmb  = eb || (m_cmb && !fclr[2]);
            m_pa   = ea;
            m_po   = ov;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("tcnt", o_tcnt, m_cnt);
        chk("cmfa", o_cmfa, m_cma);
        chk("cmfb", o_cmfb, m_cmb);
        chk("ovf", o_ovf, m_ovf);
        chk("cmia", o_cmia, m_cma & ie[1]);
        chk("cmib", o_cmib, m_cmb & ie[2]);
        chk("ovi", o_ovi, m_ovf & ie[0]);
        chk("cmpa_pulse", o_cmpa_pulse, m_pa);
        chk("ovf_pulse", o_ovf_pulse, m_po);
        chk("tmo", o_tmo, m_tmo);
        en = 0; wr = 0; ext = 0; fclr = 0;
    endtask

    initial begin
        int npls;
        rst = 1; en = 0; wr = 0; ext = 0; cclr = 0; tcora = 0; tcorb = 0;
        wdata = 0; fclr = 0; ie = 0; os = 0;
        m_cnt = 0; m_hold = 0; m_ovf = 0; m_cma = 0; m_cmb = 0;
        m_pa = 0; m_po = 0; m_tmo = 0;
        #1;

        // reset
        cyc(); rst = 1; cyc(); rst = 0;
        chk("rst_tcnt", o_tcnt, 0);
        chk("rst_flags", {o_cmfa, o_cmfb, o_ovf}, 0);

        // clear on compare A, period TCORA+1
        cclr = 2'd1; tcora = 8'd3; tcorb = 8'd200;
        npls = 0;
        for (int i = 0; i < 12; i++) begin
            en = 1; cyc();
            npls += int'(o_cmpa_pulse);
        end
        chk("cma_pulse_count", npls, 3);
        chk("cma_tcnt_end", o_tcnt, 0);
        chk("cma_flag", o_cmfa, 1);
        chk("cma_no_ovf", o_ovf, 0);
        cyc();
        chk("cma_pulse_drop", o_cmpa_pulse, 0);

        // overflow FE -> FF -> 00
        cclr = 2'd0; ie = 3'b001;
        wr = 1; wdata = 8'hFE; cyc();
        en = 1; cyc();
        chk("ovf_ff", o_tcnt, 8'hFF);
        en = 1; cyc();
        chk("ovf_wrap", o_tcnt, 0);
        chk("ovf_flag", o_ovf, 1);
        chk("ovf_pulse1", o_ovf_pulse, 1);
        chk("ovi_set", o_ovi, 1);
        cyc();
        chk("ovf_pulse_end", o_ovf_pulse, 0);
        chk("ovi_hold", o_ovi, 1);
        fclr = 3'b001; cyc();
        chk("ovi_w1c", o_ovi, 0);

        // CPU write inhibits compare B, including the following hold cycle
        fclr = 3'b111; cyc();
        tcorb = 8'd5; ie = 3'b111;
        wr = 1; wdata = 8'd4; cyc();
        cyc();
        wr = 1; wdata = 8'd5; en = 1; cyc();
        chk("wr_tcnt", o_tcnt, 5);
        chk("wr_no_cmfb", o_cmfb, 0);
        en = 1; cyc();
        chk("hold_tcnt", o_tcnt, 6);
        chk("hold_no_cmfb", o_cmfb, 0);

        // external clear without enable
        wr = 1; wdata = 8'h40; cyc();
        cyc();
        cclr = 2'd3; ext = 1; cyc();
        chk("ext_clr", o_tcnt, 0);
        chk("ext_no_flags", {o_cmfa, o_cmfb, o_ovf}, 0);

        // set beats W1C on the same cycle
        cclr = 2'd1; tcora = 8'd3;
        wr = 1; wdata = 8'd3; cyc();
        cyc();
        en = 1; fclr = 3'b010; cyc();
        chk("set_wins", o_cmfa, 1);
        chk("set_wins_tcnt", o_tcnt, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(99) == 0);
            en    = ($urandom_range(3) != 0);
            wr    = ($urandom_range(15) == 0);
            ext   = ($urandom_range(11) == 0);
            wdata = ($urandom_range(3) == 0) ? 8'hFD : 8'($urandom_range(255));
            cclr  = 2'($urandom_range(3));
            tcora = ($urandom_range(9) < 7) ? 8'($urandom_range(6)) : 8'($urandom_range(255));
            tcorb = ($urandom_range(9) < 7) ? 8'($urandom_range(6)) : 8'($urandom_range(255));
            fclr  = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd0;
            ie    = 3'($urandom_range(7));
            os    = 4'($urandom_range(15));
            cyc();
            rst = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
